// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - LC-3b shared types: word, opcode, decoded IR fields
package lc3b_types;

   typedef logic [15:0] lc3b_word;
   typedef logic [2:0]  lc3b_reg;

   typedef enum logic [3:0] {
      op_br   = 4'h0,
      op_add  = 4'h1,
      op_ldb  = 4'h2,
      op_stb  = 4'h3,
      op_jsr  = 4'h4,
      op_and  = 4'h5,
      op_ldr  = 4'h6,
      op_str  = 4'h7,
      op_rti  = 4'h8,
      op_not  = 4'h9,
      op_ldi  = 4'ha,
      op_sti  = 4'hb,
      op_jmp  = 4'hc,
      op_shf  = 4'hd,
      op_lea  = 4'he,
      op_trap = 4'hf
   } lc3b_opcode;

   // TRAP and JSR write the return address to R7.
   localparam lc3b_reg LC3B_LINK_REG = 3'b111;

   typedef struct packed {
      lc3b_opcode  opcode;
      lc3b_reg     dest;
      lc3b_reg     src1;
      lc3b_reg     src2;
      logic        imm;
      logic [4:0]  imm5;
      lc3b_word    imm4;
      logic [5:0]  offset6;
      logic [8:0]  offset9;
      logic [10:0] offset11;
      logic [7:0]  trap8;
      logic        bit11;
      logic        bit4;
   } lc3b_ir_fields;

endpackage

// File: rtl/ir_decode.sv
// rtl/ir_decode.sv - combinational LC-3b instruction word field decode
module ir_decode
   import lc3b_types::*;
(
   input  logic [15:0]   instr,
   output lc3b_ir_fields fields
);

   lc3b_opcode op;
   assign op = lc3b_opcode'(instr[15:12]);

   always_comb begin
      fields          = '0;
      fields.opcode   = op;
      fields.dest     = (op == op_trap || op == op_jsr) ? LC3B_LINK_REG : instr[11:9];
      fields.src1     = instr[8:6];
      fields.src2     = instr[2:0];
      fields.imm      = instr[5];
      fields.imm5     = instr[4:0];
      fields.imm4     = {12'h000, instr[3:0]};
      fields.offset6  = instr[5:0];
      fields.offset9  = instr[8:0];
      fields.offset11 = instr[10:0];
      fields.trap8    = instr[7:0];
      fields.bit11    = instr[11];
      fields.bit4     = instr[4];
   end

endmodule

// File: rtl/ir_queue.sv
// rtl/ir_queue.sv - instruction queue (instr+pc) with decoded head fields
module ir_queue
   import lc3b_types::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [15:0]      in_instr,
   input  logic [15:0]      in_pc,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      out_pc,
   output logic [3:0]       opcode,
   output logic [2:0]       dest,
   output logic [2:0]       src1,
   output logic [2:0]       src2,
   output logic             imm,
   output logic [4:0]       imm5,
   output logic [15:0]      imm4,
   output logic [5:0]       offset6,
   output logic [8:0]       offset9,
   output logic [10:0]      offset11,
   output logic [7:0]       trap8,
   output logic             bit11,
   output logic             bit4,
   output logic [PTR_W:0]   count
);

   localparam logic [PTR_W:0] COUNT_FULL = (PTR_W + 1)'(DEPTH);

   logic [15:0]      instr_mem [DEPTH];
   logic [15:0]      pc_mem    [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count_q;
   logic             enq;
   logic             deq;
   logic [15:0]      head_instr;
   lc3b_ir_fields    fields;

   // Handshake outputs depend only on registered occupancy.
   assign in_ready  = (count_q != COUNT_FULL);
   assign out_valid = (count_q != '0);
   assign enq       = in_valid & in_ready;
   assign deq       = out_valid & out_ready;
   assign count     = count_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else if (flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (enq) wr_ptr <= wr_ptr + 1'b1;
         if (deq) rd_ptr <= rd_ptr + 1'b1;
         case ({enq, deq})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (enq && !flush) begin
         instr_mem[wr_ptr] <= in_instr;
         pc_mem[wr_ptr]    <= in_pc;
      end
   end

   // An empty queue decodes an all-zero word so no stale entry leaks out.
   assign head_instr = out_valid ? instr_mem[rd_ptr] : '0;
   assign out_pc     = out_valid ? pc_mem[rd_ptr]    : '0;

   ir_decode u_decode (
      .instr  (head_instr),
      .fields (fields)
   );

   assign opcode   = fields.opcode;
   assign dest     = fields.dest;
   assign src1     = fields.src1;
   assign src2     = fields.src2;
   assign imm      = fields.imm;
   assign imm5     = fields.imm5;
   assign imm4     = fields.imm4;
   assign offset6  = fields.offset6;
   assign offset9  = fields.offset9;
   assign offset11 = fields.offset11;
   assign trap8    = fields.trap8;
   assign bit11    = fields.bit11;
   assign bit4     = fields.bit4;

endmodule

// File: tb/tb_ir_queue.sv
// tb/tb_ir_queue.sv - directed self-checking bench for ir_queue
module tb_ir_queue;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, out_ready;
   logic [15:0] in_instr, in_pc;
   logic        in_ready, out_valid;
   logic [15:0] out_pc, imm4;
   logic [3:0]  opcode;
   logic [2:0]  dest, src1, src2;
   logic        imm, bit11, bit4;
   logic [4:0]  imm5;
   logic [5:0]  offset6;
   logic [8:0]  offset9;
   logic [10:0] offset11;
   logic [7:0]  trap8;
   logic [2:0]  count;

   int total = 0;
   int bad   = 0;

   ir_queue #(.DEPTH(4)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .opcode(opcode), .dest(dest), .src1(src1), .src2(src2), .imm(imm),
      .imm5(imm5), .imm4(imm4), .offset6(offset6), .offset9(offset9),
      .offset11(offset11), .trap8(trap8), .bit11(bit11), .bit4(bit4),
      .count(count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      total++; if (count !== 3'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", count); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
      reset = 1'b0;
      step();
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_instr = 16'h1000 + 16'(i);
         in_pc    = 16'h3100 + 16'(i);
         step();
      end
      in_valid = 1'b0;
      total++; if (count !== 3'd3) begin bad++; $display("FAIL pre_rst_count: got %0d want 3", count); end
      #2 reset = 1'b1;
      #1;
      total++; if (count !== 3'd0) begin bad++; $display("FAIL midrst_count: got %0d want 0", count); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
      total++; if (opcode !== 4'h0) begin bad++; $display("FAIL midrst_opcode: got %0h want 0", opcode); end
      total++; if (out_pc !== 16'h0000) begin bad++; $display("FAIL midrst_out_pc: got %0h want 0", out_pc); end
      #1 reset = 1'b0;
      step();
      total++; if (count !== 3'd0) begin bad++; $display("FAIL postrst_count: got %0d want 0", count); end
   endtask

   task automatic test_add();
      in_valid = 1'b1; in_instr = 16'h12A3; in_pc = 16'h3000;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL add_no_bypass: got %b want 0", out_valid); end
      step();
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL add_out_valid: got %b want 1", out_valid); end
      total++; if (opcode !== 4'h1) begin bad++; $display("FAIL add_opcode: got %0h want 1", opcode); end
      total++; if (dest !== 3'd1) begin bad++; $display("FAIL add_dest: got %0d want 1", dest); end
      total++; if (src1 !== 3'd2) begin bad++; $display("FAIL add_src1: got %0d want 2", src1); end
      total++; if (src2 !== 3'd3) begin bad++; $display("FAIL add_src2: got %0d want 3", src2); end
      total++; if (imm !== 1'b1) begin bad++; $display("FAIL add_imm: got %b want 1", imm); end
      total++; if (imm5 !== 5'h03) begin bad++; $display("FAIL add_imm5: got %0h want 3", imm5); end
      total++; if (out_pc !== 16'h3000) begin bad++; $display("FAIL add_out_pc: got %0h want 3000", out_pc); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL add_drained: got %b want 0", out_valid); end
      total++; if (opcode !== 4'h0) begin bad++; $display("FAIL empty_opcode: got %0h want 0", opcode); end
      total++; if (dest !== 3'd0) begin bad++; $display("FAIL empty_dest: got %0d want 0", dest); end
      total++; if (out_pc !== 16'h0000) begin bad++; $display("FAIL empty_out_pc: got %0h want 0", out_pc); end
   endtask

   task automatic test_trap_jsr();
      in_valid = 1'b1; in_instr = 16'hF025; in_pc = 16'h3002;
      step();
      in_instr = 16'h4FFF; in_pc = 16'h3004;
      step();
      in_valid = 1'b0;
      total++; if (count !== 3'd2) begin bad++; $display("FAIL tj_count: got %0d want 2", count); end
      total++; if (opcode !== 4'hF) begin bad++; $display("FAIL trap_opcode: got %0h want f", opcode); end
      total++; if (dest !== 3'd7) begin bad++; $display("FAIL trap_dest: got %0d want 7", dest); end
      total++; if (trap8 !== 8'h25) begin bad++; $display("FAIL trap_trap8: got %0h want 25", trap8); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      total++; if (opcode !== 4'h4) begin bad++; $display("FAIL jsr_opcode: got %0h want 4", opcode); end
      total++; if (dest !== 3'd7) begin bad++; $display("FAIL jsr_dest: got %0d want 7", dest); end
      total++; if (bit11 !== 1'b1) begin bad++; $display("FAIL jsr_bit11: got %b want 1", bit11); end
      total++; if (offset11 !== 11'h7FF) begin bad++; $display("FAIL jsr_offset11: got %0h want 7ff", offset11); end
      total++; if (offset9 !== 9'h1FF) begin bad++; $display("FAIL jsr_offset9: got %0h want 1ff", offset9); end
      total++; if (offset6 !== 6'h3F) begin bad++; $display("FAIL jsr_offset6: got %0h want 3f", offset6); end
      total++; if (imm4 !== 16'h000F) begin bad++; $display("FAIL jsr_imm4: got %0h want f", imm4); end
      total++; if (bit4 !== 1'b1) begin bad++; $display("FAIL jsr_bit4: got %b want 1", bit4); end
      total++; if (out_pc !== 16'h3004) begin bad++; $display("FAIL jsr_out_pc: got %0h want 3004", out_pc); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL tj_drained: got %b want 0", out_valid); end
   endtask

   task automatic test_full();
      in_valid = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         in_instr = 16'hA000 + 16'(i);
         in_pc    = 16'h7000 + 16'(i);
         step();
         total++; if (count !== 3'(i)) begin bad++; $display("FAIL fill_count: got %0d want %0d", count, i); end
      end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
      in_instr = 16'hA005; in_pc = 16'h7005; out_ready = 1'b1;
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_deq_in_ready: got %b want 0", in_ready); end
      step();
      out_ready = 1'b0;
      total++; if (count !== 3'd3) begin bad++; $display("FAIL full_deq_count: got %0d want 3", count); end
      total++; if (out_pc !== 16'h7002) begin bad++; $display("FAIL full_deq_head: got %0h want 7002", out_pc); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL full_reopen: got %b want 1", in_ready); end
      step();
      in_valid = 1'b0;
      total++; if (count !== 3'd4) begin bad++; $display("FAIL retry_count: got %0d want 4", count); end
      out_ready = 1'b1;
      for (int k = 2; k <= 5; k++) begin
         total++; if (out_pc !== 16'h7000 + 16'(k)) begin bad++; $display("FAIL full_order: got %0h want %0h", out_pc, 16'h7000 + 16'(k)); end
         step();
      end
      out_ready = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL full_drained: got %b want 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_instr  = 16'h5000 + 16'(i);
         in_pc     = 16'h6000 + 16'(i);
         out_ready = (i != 0);
         step();
         total++; if (count !== 3'd1) begin bad++; $display("FAIL b2b_count: got %0d want 1", count); end
         total++; if (out_pc !== 16'h6000 + 16'(i)) begin bad++; $display("FAIL b2b_order: got %0h want %0h", out_pc, 16'h6000 + 16'(i)); end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drained: got %b want 0", out_valid); end
   endtask

   task automatic test_simul();
      in_valid = 1'b1;
      in_instr = 16'h6001; in_pc = 16'h8001; step();
      in_instr = 16'h6002; in_pc = 16'h8002; step();
      in_instr = 16'h6003; in_pc = 16'h8003; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      total++; if (count !== 3'd2) begin bad++; $display("FAIL simul_count: got %0d want 2", count); end
      total++; if (out_pc !== 16'h8002) begin bad++; $display("FAIL simul_head: got %0h want 8002", out_pc); end
      step();
      total++; if (out_pc !== 16'h8003) begin bad++; $display("FAIL simul_tail: got %0h want 8003", out_pc); end
      step();
      out_ready = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL simul_drained: got %b want 0", out_valid); end
   endtask

   task automatic test_flush();
      in_valid = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         in_instr = 16'h7000 + 16'(i);
         in_pc    = 16'h9000 + 16'(i);
         step();
      end
      total++; if (count !== 3'd3) begin bad++; $display("FAIL preflush_count: got %0d want 3", count); end
      flush = 1'b1; in_instr = 16'h7004; in_pc = 16'h9004; out_ready = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
      step();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      total++; if (count !== 3'd0) begin bad++; $display("FAIL flush_count: got %0d want 0", count); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
      total++; if (out_pc !== 16'h0000) begin bad++; $display("FAIL flush_out_pc: got %0h want 0", out_pc); end
      step();
      total++; if (count !== 3'd0) begin bad++; $display("FAIL flush_word_absent: got %0d want 0", count); end
      in_valid = 1'b1; in_instr = 16'h7005; in_pc = 16'h9005;
      step();
      in_valid = 1'b0;
      total++; if (out_pc !== 16'h9005) begin bad++; $display("FAIL postflush_head: got %0h want 9005", out_pc); end
      total++; if (count !== 3'd1) begin bad++; $display("FAIL postflush_count: got %0d want 1", count); end
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_instr = 16'h0000; in_pc = 16'h0000;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_add();
      test_trap_jsr();
      test_full();
      test_back_to_back();
      test_simul();
      test_flush();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
